// File: rtl/uart_frame_pkg.sv
// Shared constants and FSM encoding for the UART command-frame parser.
package uart_frame_pkg;

    localparam logic [7:0] HEAD_BYTE = 8'hAA;

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload storage for the frame parser: MAX_LEN bytes, one write port,
// one registered read port (one-cycle read latency). Contents are not reset.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [MAX_LEN];
    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    // Payload bytes are written in place as they arrive.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Select the addressed byte; addresses past the array read as zero.
    always_comb begin
        rd_data_d = 8'h00;
        if (int'(rd_addr) < MAX_LEN) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read data register, cleared by reset so the output starts at zero.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// UART command-frame parser: HEAD CMD LEN payload CHK.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter int         LEN_W        = 5,
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] HEAD_BYTE    = uart_frame_pkg::HEAD_BYTE,
    parameter int         TIMEOUT_CLKS = 156250
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rx_done,
    input  logic [7:0]        uart_rx_data,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [7:0]        frame_cmd,
    output logic [LEN_W-1:0]  frame_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic             byte_stb;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       cmd_r_q, cmd_r_d;
    logic [LEN_W-1:0] len_r_q, len_r_d;
    logic [LEN_W-1:0] wr_idx_q, wr_idx_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [7:0]       frame_cmd_q, frame_cmd_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             buf_we;
    logic             tmo_hit;

    assign done_d   = uart_rx_done;
    assign byte_stb = uart_rx_done & ~done_q;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Gap counter: restarts on every byte, idles at zero outside a frame; a byte wins over expiry.
    always_comb begin
        tmo_hit   = (state_q != ST_IDLE) && !byte_stb && (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        if (byte_stb || (state_q == ST_IDLE) || tmo_hit) begin
            tmo_cnt_d = '0;
        end
    end

    // Gap counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Frame FSM next-state, checksum accumulation and result pulses.
    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        cmd_r_d       = cmd_r_q;
        len_r_d       = len_r_q;
        wr_idx_d      = wr_idx_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        buf_we        = 1'b0;
        if (byte_stb) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (uart_rx_data == HEAD_BYTE) begin
                        sum_d   = 8'h00;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    cmd_r_d = uart_rx_data;
                    sum_d   = sum_q + uart_rx_data;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    sum_d = sum_q + uart_rx_data;
                    if (uart_rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else if (uart_rx_data == 8'h00) begin
                        len_r_d = '0;
                        state_d = ST_CHK;
                    end else begin
                        len_r_d  = uart_rx_data[LEN_W-1:0];
                        wr_idx_d = '0;
                        state_d  = ST_DATA;
                    end
                end
                ST_DATA: begin
                    buf_we   = 1'b1;
                    sum_d    = sum_q + uart_rx_data;
                    wr_idx_d = wr_idx_q + LEN_ONE;
                    if ((wr_idx_q + LEN_ONE) == len_r_q) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (uart_rx_data == sum_q) begin
                        frame_valid_d = 1'b1;
                        frame_cmd_d   = cmd_r_q;
                        frame_len_d   = len_r_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
            state_d     = ST_IDLE;
        end
    end

    // State, checksum and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            done_q        <= 1'b0;
            sum_q         <= 8'h00;
            cmd_r_q       <= 8'h00;
            len_r_q       <= '0;
            wr_idx_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'd0;
            frame_cmd_q   <= 8'h00;
            frame_len_q   <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            sum_q         <= sum_d;
            cmd_r_q       <= cmd_r_d;
            len_r_q       <= len_r_d;
            wr_idx_q      <= wr_idx_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
        end
    end

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W)
    ) u_buf (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (buf_we),
        .wr_addr   (wr_idx_q[ADDR_W-1:0]),
        .wr_data   (uart_rx_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_len   = frame_len_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: table vectors, hand-timed
// latency/reset/gap sequences, and randomized frames against a frame model.
module tb_uart_frame_parser;

    localparam int MAX_LEN      = 16;
    localparam int LEN_W        = 5;
    localparam int ADDR_W       = 4;
    localparam int TIMEOUT_CLKS = 156250;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              uart_rx_done;
    logic [7:0]        uart_rx_data;
    logic              frame_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [7:0]        frame_cmd;
    logic [LEN_W-1:0]  frame_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    uart_frame_parser #(
        .MAX_LEN      (MAX_LEN),
        .LEN_W        (LEN_W),
        .ADDR_W       (ADDR_W),
        .HEAD_BYTE    (8'hAA),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rx_done (uart_rx_done),
        .uart_rx_data (uart_rx_data),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .frame_cmd    (frame_cmd),
        .frame_len    (frame_len),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        int         n;
        logic [7:0] b [8];
        int         hold;
        int         expV;
        int         expE;
        logic [1:0] code;
        logic [7:0] cmd;
        int         len;
        int         nrd;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } vec_t;

    typedef struct {
        int         kind;
        logic [1:0] code;
        logic [7:0] cmd;
        int         len;
        logic [7:0] pay [16];
    } exp_t;

    int   checks    = 0;
    int   failures  = 0;
    int   vldCnt    = 0;
    int   errCnt    = 0;
    bit   bothSeen  = 1'b0;
    bit   longPulse = 1'b0;
    logic prevV     = 1'b0;
    logic prevE     = 1'b0;

    // Pulse monitor: counts result pulses and flags overlapping or stretched pulses.
    always @(negedge sys_clk) begin
        if (frame_valid) vldCnt++;
        if (frame_err) errCnt++;
        if (frame_valid && frame_err) bothSeen = 1'b1;
        if ((frame_valid && prevV) || (frame_err && prevE)) longPulse = 1'b1;
        prevV = frame_valid;
        prevE = frame_err;
    end

    // Hard stop so a stuck run still ends with a report.
    initial begin
        #(64'd50_000_000);
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int hold, input int gap);
        @(posedge sys_clk);
        #1;
        uart_rx_data = b;
        uart_rx_done = 1'b1;
        repeat (hold) @(posedge sys_clk);
        #1;
        uart_rx_done = 1'b0;
        uart_rx_data = 8'($urandom);
        repeat (gap) @(posedge sys_clk);
    endtask

    task automatic applyStimulus(input logic [7:0] q [$], input int hold, input int gap);
        foreach (q[k]) sendByte(q[k], hold, gap);
        repeat (4) @(posedge sys_clk);
    endtask

    task automatic readByte(input int addr, output logic [7:0] val);
        @(posedge sys_clk);
        #1;
        rd_addr = ADDR_W'(addr);
        @(posedge sys_clk);
        #1;
        val = rd_data;
    endtask

    task automatic verifyResult(input string tag, input int v0, input int e0, input int expV,
                                input int expE, input logic [1:0] code, input logic [7:0] cmd,
                                input int len, input int nrd, input logic [7:0] pay [16]);
        logic [7:0] got;
        checkOutput({tag, " valid pulses"}, 32'(vldCnt - v0), 32'(expV));
        checkOutput({tag, " err pulses"}, 32'(errCnt - e0), 32'(expE));
        if (expE != 0) checkOutput({tag, " err_code"}, 32'(err_code), 32'(code));
        checkOutput({tag, " frame_cmd"}, 32'(frame_cmd), 32'(cmd));
        checkOutput({tag, " frame_len"}, 32'(frame_len), 32'(len));
        checkOutput({tag, " pulse shape"}, 32'({bothSeen, longPulse}), 32'd0);
        for (int k = 0; k < nrd; k++) begin
            readByte(k, got);
            checkOutput($sformatf("%s rd_data[%0d]", tag, k), 32'(got), 32'(pay[k]));
        end
    endtask

    // Frame model: find the head byte, then judge the frame from its length and byte sum.
    function automatic exp_t refModel(input logic [7:0] q [$]);
        exp_t e;
        int   i = 0;
        int   s;
        e.kind = 0;
        e.code = 2'd0;
        e.cmd  = 8'h00;
        e.len  = 0;
        foreach (e.pay[k]) e.pay[k] = 8'h00;
        while (i < q.size() && q[i] != 8'hAA) i++;
        if (i + 2 >= q.size()) return e;
        e.cmd = q[i+1];
        e.len = int'(q[i+2]);
        if (e.len > MAX_LEN) begin
            e.kind = 2;
            e.code = 2'd2;
            return e;
        end
        s = int'(q[i+1]) + int'(q[i+2]);
        for (int k = 0; k < e.len; k++) begin
            e.pay[k] = q[i+3+k];
            s += int'(q[i+3+k]);
        end
        if (i + 3 + e.len >= q.size()) begin
            e.kind = 0;
        end else if (int'(q[i+3+e.len]) == (s % 256)) begin
            e.kind = 1;
        end else begin
            e.kind = 2;
            e.code = 2'd1;
        end
        return e;
    endfunction

    vec_t       vecs [5];
    logic [7:0] q [$];
    logic [7:0] pay [16];
    exp_t       e;
    logic [7:0] expCmd;
    int         expLen;
    int         v0;
    int         e0;

    initial begin
        sys_rst_n    = 1'b0;
        uart_rx_done = 1'b0;
        uart_rx_data = 8'h00;
        rd_addr      = '0;
        foreach (pay[k]) pay[k] = 8'h00;

        vecs[0] = '{6, '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33, 8'h00, 8'h00}, 5208, 1, 0, 2'd0, 8'h01, 2, 2, 8'h10, 8'h20};
        vecs[1] = '{6, '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34, 8'h00, 8'h00}, 4, 0, 1, 2'd1, 8'h01, 2, 0, 8'h00, 8'h00};
        vecs[2] = '{3, '{8'hAA, 8'h07, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 1, 2'd2, 8'h01, 2, 0, 8'h00, 8'h00};
        vecs[3] = '{4, '{8'hAA, 8'h05, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1, 0, 2'd0, 8'h05, 0, 0, 8'h00, 8'h00};
        vecs[4] = '{8, '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h03, 8'h01, 8'h7E, 8'h82}, 1, 1, 0, 2'd0, 8'h03, 1, 1, 8'h7E, 8'h00};

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("reset frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset err_code", 32'(err_code), 32'd0);
        checkOutput("reset frame_cmd", 32'(frame_cmd), 32'd0);
        checkOutput("reset frame_len", 32'(frame_len), 32'd0);
        checkOutput("reset rd_data", 32'(rd_data), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            q.delete();
            for (int k = 0; k < vecs[i].n; k++) q.push_back(vecs[i].b[k]);
            v0 = vldCnt;
            e0 = errCnt;
            applyStimulus(q, vecs[i].hold, 2);
            pay[0] = vecs[i].rd0;
            pay[1] = vecs[i].rd1;
            verifyResult($sformatf("vec%0d", i), v0, e0, vecs[i].expV, vecs[i].expE, vecs[i].code,
                         vecs[i].cmd, vecs[i].len, vecs[i].nrd, pay);
        end
        expCmd = 8'h03;
        expLen = 1;

        // Length-overflow error lands one cycle after the LEN strobe, done held high throughout
        sendByte(8'hAA, 2, 2);
        sendByte(8'h07, 2, 2);
        @(posedge sys_clk);
        #1;
        uart_rx_data = 8'h11;
        uart_rx_done = 1'b1;
        @(negedge sys_clk);
        checkOutput("len err before edge", 32'(frame_err), 32'd0);
        @(negedge sys_clk);
        checkOutput("len err pulse", 32'(frame_err), 32'd1);
        checkOutput("len err code", 32'(err_code), 32'd2);
        @(negedge sys_clk);
        checkOutput("len err single", 32'(frame_err), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        uart_rx_done = 1'b0;

        // Good-frame pulse timing on the CHK byte
        sendByte(8'hAA, 1, 1);
        sendByte(8'h02, 1, 1);
        sendByte(8'h00, 1, 1);
        @(posedge sys_clk);
        #1;
        uart_rx_data = 8'h02;
        uart_rx_done = 1'b1;
        @(negedge sys_clk);
        checkOutput("chk valid before edge", 32'(frame_valid), 32'd0);
        @(negedge sys_clk);
        checkOutput("chk valid pulse", 32'(frame_valid), 32'd1);
        checkOutput("chk valid cmd", 32'(frame_cmd), 32'h02);
        @(negedge sys_clk);
        checkOutput("chk valid single", 32'(frame_valid), 32'd0);
        #1;
        uart_rx_done = 1'b0;
        repeat (3) @(posedge sys_clk);

        // Reset in the middle of a frame discards it
        sendByte(8'hAA, 2, 1);
        sendByte(8'h01, 2, 1);
        #1;
        sys_rst_n = 1'b0;
        #5;
        checkOutput("midreset frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("midreset frame_err", 32'(frame_err), 32'd0);
        checkOutput("midreset err_code", 32'(err_code), 32'd0);
        checkOutput("midreset frame_cmd", 32'(frame_cmd), 32'd0);
        checkOutput("midreset frame_len", 32'(frame_len), 32'd0);
        checkOutput("midreset rd_data", 32'(rd_data), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        q = '{8'h02, 8'h10, 8'h20, 8'h33};
        v0 = vldCnt;
        e0 = errCnt;
        applyStimulus(q, 2, 1);
        verifyResult("post reset tail", v0, e0, 0, 0, 2'd0, 8'h00, 0, 0, pay);
        q = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        v0 = vldCnt;
        e0 = errCnt;
        applyStimulus(q, 3, 1);
        pay[0] = 8'h10;
        pay[1] = 8'h20;
        verifyResult("post reset frame", v0, e0, 1, 0, 2'd0, 8'h01, 2, 2, pay);
        expCmd = 8'h01;
        expLen = 2;

        // Stalled partial frame
        q = '{8'hAA, 8'h01, 8'h02};
        applyStimulus(q, 2, 1);
        v0 = vldCnt;
        e0 = errCnt;
        sendByte(8'h10, 1, 0);
`ifdef UART_FRAME_TIMEOUT_EN
        repeat (TIMEOUT_CLKS - 10) @(posedge sys_clk);
        checkOutput("timeout early", 32'(errCnt - e0), 32'd0);
        repeat (20) @(posedge sys_clk);
        verifyResult("timeout", v0, e0, 0, 1, 2'd3, expCmd, expLen, 0, pay);
`else
        repeat (3000) @(posedge sys_clk);
        checkOutput("stall no err", 32'(errCnt - e0), 32'd0);
        checkOutput("stall no valid", 32'(vldCnt - v0), 32'd0);
        q = '{8'h20, 8'h33};
        applyStimulus(q, 2, 1);
        pay[0] = 8'h10;
        pay[1] = 8'h20;
        verifyResult("stall resume", v0, e0, 1, 0, 2'd0, 8'h01, 2, 2, pay);
`endif

        // Randomized frames against the model
        for (int i = 0; i < 30; i++) begin
            int   mode;
            int   len;
            int   s;
            logic [7:0] c;
            q.delete();
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                c = 8'($urandom);
                if (c == 8'hAA) c = 8'h5A;
                q.push_back(c);
            end
            mode = (i == 0) ? 5 : int'($urandom_range(0, 9));
            c = 8'($urandom);
            q.push_back(8'hAA);
            q.push_back(c);
            if (mode == 0) begin
                q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = (i == 0) ? MAX_LEN : int'($urandom_range(0, MAX_LEN));
                q.push_back(8'(len));
                s = int'(c) + len;
                for (int k = 0; k < len; k++) begin
                    c = 8'($urandom);
                    q.push_back(c);
                    s += int'(c);
                end
                if (mode == 1) q.push_back(8'(s) ^ 8'($urandom_range(1, 255)));
                else q.push_back(8'(s));
            end
            e  = refModel(q);
            v0 = vldCnt;
            e0 = errCnt;
            applyStimulus(q, int'($urandom_range(1, 6)), int'($urandom_range(0, 4)));
            if (e.kind == 1) begin
                expCmd = e.cmd;
                expLen = e.len;
            end
            verifyResult($sformatf("rnd%0d", i), v0, e0, (e.kind == 1) ? 1 : 0, (e.kind == 2) ? 1 : 0,
                         e.code, expCmd, expLen, (e.kind == 1) ? e.len : 0, e.pay);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
